// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: state encoding of the
// elastic stage and the payload bundles carried across each stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam int ID_CTRL_W  = 14;
    localparam int MEM_CTRL_W = 6;
    localparam int WB_CTRL_W  = 3;

    localparam int IFID_W  = 2 * XLEN;
    localparam int IDEX_W  = ID_CTRL_W + 4 * XLEN + 3 * REG_IDX_W;
    localparam int EXMEM_W = MEM_CTRL_W + 2 * XLEN + REG_IDX_W;
    localparam int MEMWB_W = WB_CTRL_W + XLEN + REG_IDX_W;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [ID_CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic [MEM_CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]       alu_res;
        logic [XLEN-1:0]       rs2_val;
        logic [REG_IDX_W-1:0]  rd;
    } exmem_t;

    typedef struct packed {
        logic [WB_CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]      wb_data;
        logic [REG_IDX_W-1:0] rd;
    } memwb_t;

    // Field order in each struct defines the bit layout on the wire: first field is the MSBs.
    function automatic logic [IFID_W-1:0] ifid_pack(input ifid_t b);
        return b;
    endfunction

    function automatic ifid_t ifid_unpack(input logic [IFID_W-1:0] v);
        return ifid_t'(v);
    endfunction

    function automatic logic [IDEX_W-1:0] idex_pack(input idex_t b);
        return b;
    endfunction

    function automatic idex_t idex_unpack(input logic [IDEX_W-1:0] v);
        return idex_t'(v);
    endfunction

    function automatic logic [EXMEM_W-1:0] exmem_pack(input exmem_t b);
        return b;
    endfunction

    function automatic exmem_t exmem_unpack(input logic [EXMEM_W-1:0] v);
        return exmem_t'(v);
    endfunction

    function automatic logic [MEMWB_W-1:0] memwb_pack(input memwb_t b);
        return b;
    endfunction

    function automatic memwb_t memwb_unpack(input logic [MEMWB_W-1:0] v);
        return memwb_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush; SKID=1 adds a second entry so
// in_ready can come straight from a flop while still sustaining one transfer per cycle.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    if (SKID != 0) begin : g_skid
        state_e              state_q, state_d;
        logic [DATA_W-1:0]   main_q, main_d;
        logic [DATA_W-1:0]   skid_q, skid_d;
        logic                in_ready_q, in_ready_d;
        logic                in_fire, out_fire;

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_q;
        assign occupancy = state_q;
        assign in_fire   = in_valid & in_ready_q;
        assign out_fire  = out_valid & out_ready;

        always_comb begin
            // NOTE: every signal this block drives gets a default first, so no path infers a latch.
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            // Flush only kills the valid state; payload registers keep their contents.
            if (flush) begin
                state_d = ST_EMPTY;
                main_d  = main_q;
                skid_d  = skid_q;
            end
            in_ready_d = (state_d != ST_SKID);
        end

        always_ff @(posedge clk or posedge rst) begin
            // NOTE: sequential state is written with non-blocking assignments only.
            if (rst) begin
                state_q    <= ST_EMPTY;
                main_q     <= '0;
                skid_q     <= '0;
                in_ready_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                main_q     <= main_d;
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end
    end else begin : g_single
        state_e              state_q, state_d;
        logic [DATA_W-1:0]   main_q, main_d;
        logic                live_q, live_d;
        logic                in_fire, out_fire;

        // live_q holds in_ready low until the first edge after reset releases.
        assign out_valid = (state_q == ST_FULL);
        assign in_ready  = live_q & (~out_valid | out_ready);
        assign out_data  = main_q;
        assign occupancy = state_q;
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            live_d  = 1'b1;
            if (in_fire) begin
                state_d = ST_FULL;
                main_d  = in_data;
            end else if (out_fire) begin
                state_d = ST_EMPTY;
            end
            if (flush) begin
                state_d = ST_EMPTY;
                main_d  = main_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_EMPTY;
                main_q  <= '0;
                live_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                live_q  <= live_d;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: lane 0 is SKID=0, lane 1 is SKID=1, each compared every
// cycle against a FIFO-level model, plus directed vectors with hand-computed expectations.
module tb_pipe_stage_elastic;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [2];
    logic         out_ready [2];
    logic         flush     [2];
    logic [W-1:0] in_data   [2];

    logic         ir0, ir1, ov0, ov1;
    logic [W-1:0] od0, od1;
    logic [1:0]   oc0, oc1;

    pipe_stage_elastic #(.DATA_W(W), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0), .occupancy(oc0)
    );

    pipe_stage_elastic #(.DATA_W(W), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1), .occupancy(oc1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ir(input int k);
        return (k == 0) ? ir0 : ir1;
    endfunction
    function automatic logic get_ov(input int k);
        return (k == 0) ? ov0 : ov1;
    endfunction
    function automatic logic [W-1:0] get_od(input int k);
        return (k == 0) ? od0 : od1;
    endfunction
    function automatic logic [1:0] get_oc(input int k);
        return (k == 0) ? oc0 : oc1;
    endfunction

    // Model: a FIFO of capacity 1 (lane 0) or 2 (lane 1); out_data shows the head,
    // or the last head while empty.
    logic [W-1:0] mmem  [2][2];
    int           mcnt  [2] = '{0, 0};
    logic [W-1:0] mdata [2] = '{16'h0, 16'h0};
    bit           alive [2] = '{1'b0, 1'b0};

    function automatic bit exp_rdy(input int k);
        if (!alive[k]) return 1'b0;
        if (k == 1) return (mcnt[1] < 2);
        return (mcnt[0] == 0) || out_ready[0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k]  = 0;
                mdata[k] = '0;
                alive[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit inf, outf;
                inf  = in_valid[k] && exp_rdy(k);
                outf = (mcnt[k] > 0) && out_ready[k];
                if (flush[k]) begin
                    mcnt[k] = 0;
                end else begin
                    if (outf) begin
                        mmem[k][0] = mmem[k][1];
                        mcnt[k]--;
                    end
                    if (inf) begin
                        mmem[k][mcnt[k]] = in_data[k];
                        mcnt[k]++;
                    end
                    if (mcnt[k] > 0) mdata[k] = mmem[k][0];
                end
                alive[k] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("model L%0d in_ready", k),  32'(get_ir(k)), 32'(exp_rdy(k)));
            check($sformatf("model L%0d out_valid", k), 32'(get_ov(k)), 32'(mcnt[k] > 0));
            check($sformatf("model L%0d out_data", k),  32'(get_od(k)), 32'(mdata[k]));
            check($sformatf("model L%0d occupancy", k), 32'(get_oc(k)), 32'(mcnt[k]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic v, input logic [W-1:0] d,
                            input logic r, input logic f);
        in_valid[k]  = v;
        in_data[k]   = d;
        out_ready[k] = r;
        flush[k]     = f;
    endtask

    task automatic idle_lane(input int k);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        flush[k]     = 1'b0;
    endtask

    task automatic lit(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        check($sformatf("L%0d %s", k, name), act, exp);
    endtask

    logic [W-1:0] nxt  [2];
    bit           pend [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            idle_lane(k);
            in_data[k] = '0;
        end
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            lit(k, "rst out_valid", get_ov(k), 0);
            lit(k, "rst out_data",  get_od(k), 0);
            lit(k, "rst occupancy", get_oc(k), 0);
            lit(k, "rst in_ready",  get_ir(k), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) lit(k, "in_ready before first edge", get_ir(k), 0);
        step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) lit(k, "in_ready after first edge", get_ir(k), 1);
        step();

        // Streaming 0x1..0x10 with out_ready high: each value one cycle later, no gaps
        for (int i = 1; i <= 17; i++) begin
            for (int k = 0; k < 2; k++) set_lane(k, i <= 16, W'(i), 1'b1, 1'b0);
            @(negedge clk);
            if (i > 1) begin
                for (int k = 0; k < 2; k++) begin
                    lit(k, "stream out_data",  get_od(k), i - 1);
                    lit(k, "stream out_valid", get_ov(k), 1);
                end
            end
            step();
        end

        // Reset asserted mid-stream clears outputs without a clock edge
        for (int k = 0; k < 2; k++) set_lane(k, 1'b1, 16'h21, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 2; k++) set_lane(k, 1'b1, 16'h22, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            lit(k, "midrst out_valid", get_ov(k), 0);
            lit(k, "midrst out_data",  get_od(k), 0);
            lit(k, "midrst occupancy", get_oc(k), 0);
            lit(k, "midrst in_ready",  get_ir(k), 0);
            idle_lane(k);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) lit(k, "midrst in_ready held", get_ir(k), 0);
        step();

        // Stall, SKID=1: A,B,C; out_ready low for 3 cycles while B is at the output
        idle_lane(0);
        set_lane(1, 1'b1, 16'hA, 1'b1, 1'b0); @(negedge clk); step();
        set_lane(1, 1'b1, 16'hB, 1'b1, 1'b0); @(negedge clk);
        lit(1, "stall A out", od1, 16'hA); step();
        set_lane(1, 1'b1, 16'hC, 1'b0, 1'b0); @(negedge clk);
        lit(1, "stall B out", od1, 16'hB);
        lit(1, "stall in_ready on drop", ir1, 1); step();
        set_lane(1, 1'b1, 16'hD, 1'b0, 1'b0); @(negedge clk);
        lit(1, "stall occupancy", oc1, 2);
        lit(1, "stall in_ready", ir1, 0);
        lit(1, "stall B held", od1, 16'hB); step();
        @(negedge clk); lit(1, "stall occupancy 2nd", oc1, 2); step();
        set_lane(1, 1'b1, 16'hD, 1'b1, 1'b0); @(negedge clk);
        lit(1, "release in_ready", ir1, 0); step();
        @(negedge clk);
        lit(1, "release C out", od1, 16'hC);
        lit(1, "release occupancy", oc1, 1); step();
        idle_lane(1); @(negedge clk);
        lit(1, "release D out", od1, 16'hD); step();
        @(negedge clk); lit(1, "drained", ov1, 0); step();

        // Stall, SKID=0: in_ready follows out_ready in the same cycle
        idle_lane(1);
        set_lane(0, 1'b1, 16'hA, 1'b1, 1'b0); @(negedge clk); step();
        set_lane(0, 1'b1, 16'hB, 1'b1, 1'b0); @(negedge clk);
        lit(0, "stall A out", od0, 16'hA); step();
        set_lane(0, 1'b1, 16'hC, 1'b0, 1'b0); @(negedge clk);
        lit(0, "stall B out", od0, 16'hB);
        lit(0, "stall in_ready", ir0, 0);
        lit(0, "stall occupancy", oc0, 1); step();
        @(negedge clk); lit(0, "stall B held", od0, 16'hB); step();
        @(negedge clk); step();
        set_lane(0, 1'b1, 16'hC, 1'b1, 1'b0); @(negedge clk);
        lit(0, "release in_ready", ir0, 1); step();
        set_lane(0, 1'b1, 16'hD, 1'b1, 1'b0); @(negedge clk);
        lit(0, "release C out", od0, 16'hC); step();
        idle_lane(0); @(negedge clk);
        lit(0, "release D out", od0, 16'hD); step();
        @(negedge clk); lit(0, "drained", ov0, 0); step();

        // Flush while in SKID with in_valid high; then 0xBEEF emerges alone
        idle_lane(0);
        set_lane(1, 1'b1, 16'h11, 1'b0, 1'b0); @(negedge clk); step();
        set_lane(1, 1'b1, 16'h22, 1'b0, 1'b0); @(negedge clk);
        lit(1, "pre-flush out", od1, 16'h11); step();
        set_lane(1, 1'b1, 16'h33, 1'b0, 1'b1); @(negedge clk);
        lit(1, "pre-flush occupancy", oc1, 2); step();
        set_lane(1, 1'b1, 16'hBEEF, 1'b0, 1'b0); @(negedge clk);
        lit(1, "flush out_valid", ov1, 0);
        lit(1, "flush occupancy", oc1, 0);
        lit(1, "flush out_data kept", od1, 16'h11); step();
        set_lane(1, 1'b0, 16'hBEEF, 1'b1, 1'b0); @(negedge clk);
        lit(1, "beef out", od1, 16'hBEEF);
        lit(1, "beef alone", oc1, 1); step();
        @(negedge clk); lit(1, "beef drained", ov1, 0); step();

        // Flush + input fire + output fire together
        set_lane(1, 1'b1, 16'h66, 1'b0, 1'b0); @(negedge clk); step();
        set_lane(1, 1'b1, 16'h77, 1'b1, 1'b1); @(negedge clk);
        lit(1, "triple in_ready", ir1, 1);
        lit(1, "triple out", od1, 16'h66); step();
        idle_lane(1); @(negedge clk);
        lit(1, "triple out_valid", ov1, 0);
        lit(1, "triple out_data kept", od1, 16'h66); step();

        // Flush in SKID=0 with a held upstream payload
        set_lane(0, 1'b1, 16'h44, 1'b0, 1'b0); @(negedge clk); step();
        set_lane(0, 1'b1, 16'h55, 1'b0, 1'b1); @(negedge clk);
        lit(0, "flush in_ready", ir0, 0); step();
        idle_lane(0); @(negedge clk);
        lit(0, "flush out_valid", ov0, 0);
        lit(0, "flush out_data kept", od0, 16'h44); step();

        // Random valid/ready/flush; upstream holds data while stalled
        nxt[0] = 16'h1000;
        nxt[1] = 16'h2000;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k]) begin
                    in_valid[k] = ($urandom_range(0, 3) != 0);
                    in_data[k]  = nxt[k];
                end
                out_ready[k] = ($urandom_range(0, 3) != 0);
                flush[k]     = ($urandom_range(0, 49) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                pend[k] = in_valid[k] && !get_ir(k);
                if (in_valid[k] && get_ir(k)) nxt[k] = nxt[k] + 16'd1;
            end
            step();
        end
        for (int k = 0; k < 2; k++) idle_lane(k);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
